// File: rtl/mips_controller.sv
// ============================================================================
//  Module      : mips_controller
//  Description : Registered control unit for a single-cycle MIPS datapath.
//                Decodes opcode/funct into datapath controls and the 3-bit
//                ALU operation, and forms the branch-taken select from the
//                ALU zero flag. All outputs update on the rising clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memtoreg,
  output logic       memwrite,
  output logic       pcsrc,
  output logic       alusrc,
  output logic       regdst,
  output logic       regwrite,
  output logic       jump,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  // Opcodes
  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_J     = 6'b000010;

  // R-type function codes
  localparam logic [5:0] C_FN_ADD = 6'b100000;
  localparam logic [5:0] C_FN_SUB = 6'b100010;
  localparam logic [5:0] C_FN_AND = 6'b100100;
  localparam logic [5:0] C_FN_OR  = 6'b100101;
  localparam logic [5:0] C_FN_SLT = 6'b101010;

  // ALU operation encodings
  localparam logic [2:0] C_ALU_AND = 3'b000;
  localparam logic [2:0] C_ALU_OR  = 3'b001;
  localparam logic [2:0] C_ALU_ADD = 3'b010;
  localparam logic [2:0] C_ALU_SUB = 3'b110;
  localparam logic [2:0] C_ALU_SLT = 3'b111;

  logic       memtoreg_d, memtoreg_q;
  logic       memwrite_d, memwrite_q;
  logic       pcsrc_d,    pcsrc_q;
  logic       alusrc_d,   alusrc_q;
  logic       regdst_d,   regdst_q;
  logic       regwrite_d, regwrite_q;
  logic       jump_d,     jump_q;
  logic [2:0] alucontrol_d, alucontrol_q;
  logic       illegal_d,  illegal_q;

  logic       w_branch;
  logic [1:0] w_aluop;

  // Main decoder, ALU decoder and branch select; unused fields default to 0
  always_comb begin
    memtoreg_d   = 1'b0;
    memwrite_d   = 1'b0;
    alusrc_d     = 1'b0;
    regdst_d     = 1'b0;
    regwrite_d   = 1'b0;
    jump_d       = 1'b0;
    illegal_d    = 1'b0;
    w_branch     = 1'b0;
    w_aluop      = 2'b00;
    alucontrol_d = C_ALU_ADD;

    case (op)
      C_OP_RTYPE: begin
        regwrite_d = 1'b1;
        regdst_d   = 1'b1;
        w_aluop    = 2'b10;
      end
      C_OP_LW: begin
        regwrite_d = 1'b1;
        alusrc_d   = 1'b1;
        memtoreg_d = 1'b1;
      end
      C_OP_SW: begin
        alusrc_d   = 1'b1;
        memwrite_d = 1'b1;
      end
      C_OP_BEQ: begin
        w_branch = 1'b1;
        w_aluop  = 2'b01;
      end
      C_OP_ADDI: begin
        regwrite_d = 1'b1;
        alusrc_d   = 1'b1;
      end
      C_OP_J: begin
        jump_d = 1'b1;
      end
      default: begin
        illegal_d = 1'b1;
      end
    endcase

    case (w_aluop)
      2'b00: alucontrol_d = C_ALU_ADD;
      2'b01: alucontrol_d = C_ALU_SUB;
      2'b10: begin
        case (funct)
          C_FN_ADD: alucontrol_d = C_ALU_ADD;
          C_FN_SUB: alucontrol_d = C_ALU_SUB;
          C_FN_AND: alucontrol_d = C_ALU_AND;
          C_FN_OR:  alucontrol_d = C_ALU_OR;
          C_FN_SLT: alucontrol_d = C_ALU_SLT;
          default: begin
            // Unknown R-type function: block the register write
            alucontrol_d = C_ALU_AND;
            regwrite_d   = 1'b0;
            illegal_d    = 1'b1;
          end
        endcase
      end
      default: alucontrol_d = C_ALU_AND;
    endcase

    pcsrc_d = w_branch & zero;
  end

  // Output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      memtoreg_q   <= 1'b0;
      memwrite_q   <= 1'b0;
      pcsrc_q      <= 1'b0;
      alusrc_q     <= 1'b0;
      regdst_q     <= 1'b0;
      regwrite_q   <= 1'b0;
      jump_q       <= 1'b0;
      alucontrol_q <= 3'b000;
      illegal_q    <= 1'b0;
    end else begin
      memtoreg_q   <= memtoreg_d;
      memwrite_q   <= memwrite_d;
      pcsrc_q      <= pcsrc_d;
      alusrc_q     <= alusrc_d;
      regdst_q     <= regdst_d;
      regwrite_q   <= regwrite_d;
      jump_q       <= jump_d;
      alucontrol_q <= alucontrol_d;
      illegal_q    <= illegal_d;
    end
  end

  assign memtoreg   = memtoreg_q;
  assign memwrite   = memwrite_q;
  assign pcsrc      = pcsrc_q;
  assign alusrc     = alusrc_q;
  assign regdst     = regdst_q;
  assign regwrite   = regwrite_q;
  assign jump       = jump_q;
  assign alucontrol = alucontrol_q;
  assign illegal    = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_controller.sv
// ============================================================================
//  Module      : tb_mips_controller
//  Description : Self-checking bench for mips_controller: directed vector
//                table, hand-written latency/reset sequences, and random
//                stimulus compared against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_controller;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memtoreg, memwrite, pcsrc, alusrc, regdst, regwrite, jump, illegal;
  logic [2:0] alucontrol;

  int errors = 0;
  int checks = 0;

  mips_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .memtoreg   (memtoreg),
    .memwrite   (memwrite),
    .pcsrc      (pcsrc),
    .alusrc     (alusrc),
    .regdst     (regdst),
    .regwrite   (regwrite),
    .jump       (jump),
    .alucontrol (alucontrol),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed expectation: {memtoreg,memwrite,pcsrc,alusrc,regdst,regwrite,jump,alucontrol[2:0],illegal}
  function automatic logic [10:0] pk(input logic mtr, input logic mw, input logic pc,
                                     input logic as, input logic rd, input logic rw,
                                     input logic j, input logic [2:0] alu, input logic ill);
    return {mtr, mw, pc, as, rd, rw, j, alu, ill};
  endfunction

  function automatic logic [10:0] dut_outs();
    return {memtoreg, memwrite, pcsrc, alusrc, regdst, regwrite, jump, alucontrol, illegal};
  endfunction

  // Reference model: boolean description of each instruction class
  function automatic logic [10:0] model(input logic r, input logic [5:0] o,
                                        input logic [5:0] f, input logic z);
    logic is_r, is_lw, is_sw, is_beq, is_addi, is_j, known, f_ok;
    logic [2:0] alu;
    if (!r) return 11'd0;
    is_r    = (o == 6'd0);
    is_lw   = (o == 6'd35);
    is_sw   = (o == 6'd43);
    is_beq  = (o == 6'd4);
    is_addi = (o == 6'd8);
    is_j    = (o == 6'd2);
    known   = is_r | is_lw | is_sw | is_beq | is_addi | is_j;
    f_ok    = (f == 6'd32) || (f == 6'd34) || (f == 6'd36) || (f == 6'd37) || (f == 6'd42);
    if (is_beq) alu = 3'd6;
    else if (is_r) begin
      if      (f == 6'd32) alu = 3'd2;
      else if (f == 6'd34) alu = 3'd6;
      else if (f == 6'd37) alu = 3'd1;
      else if (f == 6'd42) alu = 3'd7;
      else                 alu = 3'd0;
    end else alu = 3'd2;
    return pk(is_lw, is_sw, is_beq & z, is_lw | is_sw | is_addi, is_r,
              is_lw | is_addi | (is_r & f_ok), is_j, alu,
              ~known | (is_r & ~f_ok));
  endfunction

  task automatic check(input string name, input logic [10:0] exp);
    logic [10:0] got;
    got = dut_outs();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%b expected=%b", name, got, exp);
    end
  endtask

  // Drive on the falling edge, check 1 time unit after the next rising edge
  task automatic step(input logic r, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input string name, input logic [10:0] exp);
    @(negedge clk);
    rst_n = r; op = o; funct = f; zero = z;
    @(posedge clk);
    #1;
    check(name, exp);
  endtask

  typedef struct {
    string      name;
    logic       r;
    logic [5:0] o;
    logic [5:0] f;
    logic       z;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[20];
  int   nvec;

  task automatic add_vec(input string name, input logic r, input logic [31:0] inst,
                         input logic z, input logic [10:0] exp);
    vecs[nvec].name = name;
    vecs[nvec].r    = r;
    vecs[nvec].o    = inst[31:26];
    vecs[nvec].f    = inst[5:0];
    vecs[nvec].z    = z;
    vecs[nvec].exp  = exp;
    nvec++;
  endtask

  initial begin
    logic [5:0] ops [7];
    logic [5:0] fns [6];
    logic       r, z;
    logic [5:0] o, f;

    rst_n = 1'b0; op = 6'd0; funct = 6'b100000; zero = 1'b0;
    nvec  = 0;

    // Directed table: {mtr,mw,pc,as,rd,rw,j,alu,ill}
    add_vec("reset0",     1'b0, 32'h00000020, 1'b0, pk(0,0,0,0,0,0,0,3'b000,0));
    add_vec("reset1",     1'b0, 32'h00000020, 1'b0, pk(0,0,0,0,0,0,0,3'b000,0));
    add_vec("release",    1'b1, 32'h00000020, 1'b0, pk(0,0,0,0,1,1,0,3'b010,0));
    add_vec("addi_a",     1'b1, 32'h20020005, 1'b0, pk(0,0,0,1,0,1,0,3'b010,0));
    add_vec("addi_b",     1'b1, 32'h2067fff7, 1'b0, pk(0,0,0,1,0,1,0,3'b010,0));
    add_vec("r_or",       1'b1, 32'h00e22025, 1'b0, pk(0,0,0,0,1,1,0,3'b001,0));
    add_vec("r_and",      1'b1, 32'h00642824, 1'b0, pk(0,0,0,0,1,1,0,3'b000,0));
    add_vec("r_add",      1'b1, 32'h00a42820, 1'b0, pk(0,0,0,0,1,1,0,3'b010,0));
    add_vec("r_slt",      1'b1, 32'h0064202a, 1'b0, pk(0,0,0,0,1,1,0,3'b111,0));
    add_vec("r_sub",      1'b1, 32'h00e23822, 1'b0, pk(0,0,0,0,1,1,0,3'b110,0));
    add_vec("beq_taken",  1'b1, 32'h10a7000a, 1'b1, pk(0,0,1,0,0,0,0,3'b110,0));
    add_vec("beq_not",    1'b1, 32'h10a7000a, 1'b0, pk(0,0,0,0,0,0,0,3'b110,0));
    add_vec("addi_zero",  1'b1, 32'h20020005, 1'b1, pk(0,0,0,1,0,1,0,3'b010,0));
    add_vec("lw",         1'b1, 32'h8c020050, 1'b0, pk(1,0,0,1,0,1,0,3'b010,0));
    add_vec("sw",         1'b1, 32'hac020054, 1'b0, pk(0,1,0,1,0,0,0,3'b010,0));
    add_vec("j",          1'b1, 32'h08000011, 1'b1, pk(0,0,0,0,0,0,1,3'b010,0));
    add_vec("bad_op",     1'b1, 32'hfc000000, 1'b1, pk(0,0,0,0,0,0,0,3'b010,1));
    add_vec("bad_funct",  1'b1, 32'h00000007, 1'b0, pk(0,0,0,0,1,0,0,3'b000,1));

    for (int i = 0; i < nvec; i++)
      step(vecs[i].r, vecs[i].o, vecs[i].f, vecs[i].z, vecs[i].name, vecs[i].exp);

    // Latency: inputs changing between edges must not disturb outputs
    step(1'b1, 6'b100011, 6'd0, 1'b0, "lat_lw", pk(1,0,0,1,0,1,0,3'b010,0));
    #2;
    op = 6'b000010; zero = 1'b1;
    #1;
    check("lat_hold", pk(1,0,0,1,0,1,0,3'b010,0));
    @(posedge clk);
    #1;
    check("lat_update", pk(0,0,0,0,0,0,1,3'b010,0));

    // Reset asserted mid-stream, then decode resumes
    step(1'b1, 6'b000100, 6'd0, 1'b1, "mid_beq", pk(0,0,1,0,0,0,0,3'b110,0));
    step(1'b0, 6'b000100, 6'd0, 1'b1, "mid_rst", pk(0,0,0,0,0,0,0,3'b000,0));
    step(1'b1, 6'b000100, 6'd0, 1'b1, "mid_resume", pk(0,0,1,0,0,0,0,3'b110,0));

    // Random stimulus against the reference model
    ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd2, 6'd63};
    fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd7};
    for (int k = 0; k < 400; k++) begin
      r = ($urandom_range(0, 15) != 0);
      o = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
      z = 1'($urandom);
      step(r, o, f, z, $sformatf("rand%0d_op%b_fn%b_z%b_r%b", k, o, f, z, r),
           model(r, o, f, z));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mips_controller.md
Name: mips_controller

Overview:
Control unit for the single-cycle MIPS datapath. It decodes the instruction opcode and function fields into datapath control signals and the 3-bit ALU operation. It also forms the branch-taken select from the ALU zero flag. All outputs are registered: decode happens on the clock edge and holds for the following cycle.

Parameters:
None.

Ports:
clk         input   1  system clock; all state updates on rising edge
rst_n       input   1  synchronous reset, active-low
op          input   6  instruction opcode, inst[31:26]
funct       input   6  R-type function field, inst[5:0]
zero        input   1  ALU zero flag from the datapath
memtoreg    output  1  register write-back data comes from memory
memwrite    output  1  data-memory write enable
pcsrc       output  1  next PC = branch target (branch taken)
alusrc      output  1  ALU B operand is the sign-extended immediate
regdst      output  1  destination register is rd (1) or rt (0)
regwrite    output  1  register-file write enable
jump        output  1  next PC = jump target
alucontrol  output  3  ALU operation select
illegal     output  1  opcode or funct not supported

Behaviour:
- Reset: on a rising clk edge with rst_n=0, all outputs go to 0. Reset has priority over decode.
- Latency: on each rising edge with rst_n=1, op, funct and zero are sampled. The decoded outputs are valid after that edge (1-cycle latency) and hold until the next edge. No outputs are combinational.
- Main decoder, with internal branch and aluop[1:0]. Field order below: regwrite, regdst, alusrc, branch, memwrite, memtoreg, jump, aluop.
  - 000000 R-type: 1,1,0,0,0,0,0,10
  - 100011 lw: 1,0,1,0,0,1,0,00
  - 101011 sw: 0,0,1,0,1,0,0,00
  - 000100 beq: 0,0,0,1,0,0,0,01
  - 001000 addi: 1,0,1,0,0,0,0,00
  - 000010 j: 0,0,0,0,0,0,1,00
  - Any other op: all zero, aluop=00, illegal=1.
- ALU decoder:
  - aluop 00 -> 010 (add).
  - aluop 01 -> 110 (subtract).
  - aluop 10 decodes funct:
    - 100000 add -> 010
    - 100010 sub -> 110
    - 100100 and -> 000
    - 100101 or -> 001
    - 101010 slt -> 111
  - Unsupported funct with R-type: alucontrol=000, regwrite forced to 0, illegal=1.
- pcsrc is registered as (branch AND zero), using zero sampled at the same edge as op. Non-branch ops give pcsrc=0 regardless of zero.
- illegal=0 for all supported encodings.
- Don't-care fields in the ISA are driven to 0 so outputs are fully deterministic: regdst/memtoreg for sw/beq/j, alusrc for j.
- No X propagation: every op/funct combination produces defined outputs.
- Reset asserted mid-stream: outputs are 0 from the next edge. Decode resumes on the first edge with rst_n=1.

Test Plan:
- Reset: rst_n=0 for 2 edges with op=000000, funct=100000 -> all outputs 0. Release; next edge -> regwrite=1, regdst=1, alucontrol=010.
- addi: inst 0x20020005, then 0x2067fff7 -> regwrite=1, alusrc=1, regdst=0, memtoreg=0, memwrite=0, jump=0, pcsrc=0, alucontrol=010, illegal=0.
- R-type sweep, one per edge:
  - 0x00e22025 (or) -> alucontrol=001
  - 0x00642824 (and) -> 000
  - 0x00a42820 (add) -> 010
  - 0x0064202a (slt) -> 111
  - 0x...22 (sub) -> 110
  - Each with regwrite=1, regdst=1, alusrc=0.
- beq 0x10a7000a: zero=1 -> pcsrc=1, alucontrol=110, regwrite=0. Same instruction with zero=0 -> pcsrc=0. An addi with zero=1 -> pcsrc=0.
- Memory and jump:
  - lw (op 100011) -> memtoreg=1, alusrc=1, regwrite=1, alucontrol=010.
  - sw (op 101011) -> memwrite=1, regwrite=0.
  - j (op 000010) -> jump=1, all others 0.
- Illegal and latency:
  - op=111111 -> illegal=1, all controls 0.
  - R-type with funct=000111 -> illegal=1, regwrite=0.
  - Changing op between edges does not change outputs until the next rising edge.
